// File: rtl/hack_pkg.sv
// Shared definitions for the Hack program-counter controller.
// Holds the default word width, FSM state encoding and named jump-field codes.
package hack_pkg;

   localparam int WORD_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Hack jump field {j1,j2,j3}: j1 = out<0, j2 = out==0, j3 = out>0
   localparam logic [2:0] JNULL = 3'b000;
   localparam logic [2:0] JGT   = 3'b001;
   localparam logic [2:0] JEQ   = 3'b010;
   localparam logic [2:0] JGE   = 3'b011;
   localparam logic [2:0] JLT   = 3'b100;
   localparam logic [2:0] JNE   = 3'b101;
   localparam logic [2:0] JLE   = 3'b110;
   localparam logic [2:0] JMP   = 3'b111;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump decision for a Hack C-instruction.
// The zr=ng=1 flag combination is deliberately not special-cased.
module hack_jump_cond
   import hack_pkg::*;
(
   input  logic [2:0] jbits,
   input  logic       zr,
   input  logic       ng,
   input  logic       is_c,
   output logic       take
);

   assign take = is_c & ((jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & ~ng & ~zr));

endmodule

// File: rtl/hack_pc_ctrl.sv
// Hack program counter with IDLE/RUN/FLUSH sequencing, stall, synchronous clear
// and a sticky flag recording the first increment wrap from all-ones to zero.
module hack_pc_ctrl
   import hack_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic              is_c,
   input  logic [2:0]        jbits,
   input  logic              zr,
   input  logic              ng,
   input  logic [WORD_W-1:0] target,
   output logic [WORD_W-1:0] pc,
   output logic              jumped,
   output logic              flush,
   output logic              wrapped
);

   state_t            state;
   logic              take;
   logic [WORD_W:0]   pc_inc;

   hack_jump_cond u_jump_cond (
      .jbits (jbits),
      .zr    (zr),
      .ng    (ng),
      .is_c  (is_c),
      .take  (take)
   );

   // The extra carry bit marks the all-ones to zero rollover
   assign pc_inc = {1'b0, pc} + {{WORD_W{1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= '0;
         jumped  <= 1'b0;
         flush   <= 1'b0;
         wrapped <= 1'b0;
      end else if (clr) begin
         state   <= IDLE;
         pc      <= '0;
         jumped  <= 1'b0;
         flush   <= 1'b0;
         wrapped <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: begin
               state <= RUN;
            end
            RUN: begin
               if (take) begin
                  pc     <= target;
                  jumped <= 1'b1;
                  flush  <= 1'b1;
                  state  <= FLUSH;
               end else begin
                  pc     <= pc_inc[WORD_W-1:0];
                  jumped <= 1'b0;
                  if (pc_inc[WORD_W]) begin
                     wrapped <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               // The instruction fetched behind a jump is dropped; pc stays on the target
               jumped <= 1'b0;
               flush  <= 1'b0;
               state  <= RUN;
            end
            default: begin
               state <= IDLE;
               flush <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hack_pc_ctrl.sv
// Directed self-checking bench for hack_pc_ctrl with hand-computed expectations.
module tb_hack_pc_ctrl;
   import hack_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        en;
   logic        is_c;
   logic [2:0]  jbits;
   logic        zr;
   logic        ng;
   logic [15:0] target;
   logic [15:0] pc;
   logic        jumped;
   logic        flush;
   logic        wrapped;

   int errors = 0;
   int checks = 0;

   hack_pc_ctrl #(.WORD_W(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .en      (en),
      .is_c    (is_c),
      .jbits   (jbits),
      .zr      (zr),
      .ng      (ng),
      .target  (target),
      .pc      (pc),
      .jumped  (jumped),
      .flush   (flush),
      .wrapped (wrapped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_run();
      clr = 1'b1; en = 1'b0; is_c = 1'b0;
      tick();
      clr = 1'b0; en = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [15:0] exp_seq [4];
      exp_seq = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
      #3;
      checks++;
      if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
      checks++;
      if ({jumped, flush, wrapped} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b want 000", {jumped, flush, wrapped});
      end
      tick();
      rst_n = 1'b1; en = 1'b1;
      checks++;
      if (pc !== 16'h0000) begin errors++; $display("FAIL start_pc0: got %h want 0000", pc); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (pc !== exp_seq[i]) begin
            errors++; $display("FAIL start_seq[%0d]: got %h want %h", i, pc, exp_seq[i]);
         end
      end
   endtask

   task automatic test_stall();
      go_run();
      tick();
      en = 1'b0;
      tick();
      tick();
      checks++;
      if (pc !== 16'h0001 || jumped !== 1'b0 || flush !== 1'b0) begin
         errors++; $display("FAIL stall_run: got pc=%h j=%b f=%b want pc=0001 j=0 f=0", pc, jumped, flush);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      tick();
      checks++;
      if (pc !== 16'h0000 || flush !== 1'b0) begin
         errors++; $display("FAIL stall_idle: got pc=%h f=%b want pc=0000 f=0", pc, flush);
      end
   endtask

   task automatic test_jump_table();
      // Bit j of each mask is set where jbits=j must jump for that flag pattern
      logic [7:0] mask_tbl [4];
      logic       ng_tbl   [4];
      logic       zr_tbl   [4];
      logic [7:0] m;
      logic [15:0] exp_pc;
      mask_tbl = '{8'hF0, 8'hCC, 8'hAA, 8'hFC};
      ng_tbl   = '{1'b1, 1'b0, 1'b0, 1'b1};
      zr_tbl   = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 8; j++) begin
               go_run();
               m      = mask_tbl[p];
               exp_pc = (c == 1 && m[j]) ? 16'h1234 : 16'h0001;
               is_c   = (c == 1);
               jbits  = 3'(j);
               ng     = ng_tbl[p];
               zr     = zr_tbl[p];
               target = 16'h1234;
               tick();
               checks++;
               if (pc !== exp_pc || jumped !== (exp_pc == 16'h1234)) begin
                  errors++;
                  $display("FAIL jump is_c=%0d ng=%b zr=%b jbits=%0d: got pc=%h j=%b want pc=%h",
                           c, ng, zr, j, pc, jumped, exp_pc);
               end
               is_c = 1'b0; ng = 1'b0; zr = 1'b0;
            end
         end
      end
   endtask

   task automatic test_flush();
      go_run();
      is_c = 1'b1; jbits = JMP; target = 16'h1234;
      tick();
      is_c = 1'b0; en = 1'b0;
      checks++;
      if (pc !== 16'h1234 || flush !== 1'b1 || jumped !== 1'b1) begin
         errors++; $display("FAIL flush_enter: got pc=%h f=%b j=%b want 1234 1 1", pc, flush, jumped);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (pc !== 16'h1234 || flush !== 1'b1) begin
            errors++; $display("FAIL flush_hold[%0d]: got pc=%h f=%b want 1234 1", i, pc, flush);
         end
      end
      en = 1'b1; is_c = 1'b1; jbits = JMP; target = 16'h0777;
      tick();
      is_c = 1'b0;
      checks++;
      if (pc !== 16'h1234 || flush !== 1'b0 || jumped !== 1'b0) begin
         errors++; $display("FAIL flush_exit: got pc=%h f=%b j=%b want 1234 0 0", pc, flush, jumped);
      end
      tick();
      checks++;
      if (pc !== 16'h1235) begin errors++; $display("FAIL flush_next: got %h want 1235", pc); end
   endtask

   task automatic test_wrap();
      go_run();
      is_c = 1'b1; jbits = JMP; target = 16'h0000;
      tick();
      checks++;
      if (pc !== 16'h0000 || wrapped !== 1'b0) begin
         errors++; $display("FAIL wrap_jump0: got pc=%h w=%b want 0000 0", pc, wrapped);
      end
      is_c = 1'b0;
      tick();
      is_c = 1'b1; target = 16'hFFFF;
      tick();
      is_c = 1'b0;
      tick();
      checks++;
      if (pc !== 16'hFFFF || wrapped !== 1'b0) begin
         errors++; $display("FAIL wrap_pre: got pc=%h w=%b want FFFF 0", pc, wrapped);
      end
      tick();
      checks++;
      if (pc !== 16'h0000 || wrapped !== 1'b1) begin
         errors++; $display("FAIL wrap_inc: got pc=%h w=%b want 0000 1", pc, wrapped);
      end
      is_c = 1'b1; target = 16'h0000;
      tick();
      is_c = 1'b0;
      checks++;
      if (pc !== 16'h0000 || wrapped !== 1'b1 || jumped !== 1'b1) begin
         errors++; $display("FAIL wrap_sticky: got pc=%h w=%b j=%b want 0000 1 1", pc, wrapped, jumped);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (wrapped !== 1'b0) begin errors++; $display("FAIL wrap_clr: got %b want 0", wrapped); end
   endtask

   task automatic test_simultaneous();
      go_run();
      tick();
      clr = 1'b1; en = 1'b1; is_c = 1'b1; jbits = JMP; target = 16'h4321;
      tick();
      clr = 1'b0; is_c = 1'b0;
      checks++;
      if (pc !== 16'h0000 || jumped !== 1'b0 || flush !== 1'b0) begin
         errors++; $display("FAIL clr_prio: got pc=%h j=%b f=%b want 0000 0 0", pc, jumped, flush);
      end
      tick();
      checks++;
      if (pc !== 16'h0000) begin errors++; $display("FAIL clr_idle: got %h want 0000", pc); end
      tick();
      checks++;
      if (pc !== 16'h0001) begin errors++; $display("FAIL clr_resume: got %h want 0001", pc); end
   endtask

   task automatic test_async_reset();
      go_run();
      is_c = 1'b1; jbits = JMP; target = 16'h1234;
      tick();
      is_c = 1'b0; en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pc !== 16'h0000 || {jumped, flush, wrapped} !== 3'b000) begin
         errors++;
         $display("FAIL async_rst: got pc=%h flags=%b want 0000 000", pc, {jumped, flush, wrapped});
      end
      tick();
      rst_n = 1'b1; en = 1'b1;
      tick();
      checks++;
      if (pc !== 16'h0000 || flush !== 1'b0) begin
         errors++; $display("FAIL rst_resume_idle: got pc=%h f=%b want 0000 0", pc, flush);
      end
      tick();
      checks++;
      if (pc !== 16'h0001) begin errors++; $display("FAIL rst_resume_run: got %h want 0001", pc); end
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; en = 1'b0; is_c = 1'b0;
      jbits = JNULL; zr = 1'b0; ng = 1'b0; target = 16'h0000;
      $display("[TB] start");
      test_reset();
      test_stall();
      test_jump_table();
      test_flush();
      test_wrap();
      test_simultaneous();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hack_pc_ctrl.md
HACK_PC_CTRL -- requirements
Module: hack_pc_ctrl

Interface
REQ-001 Parameter: WORD_W, default 16, width of the program counter and the jump target.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  Asynchronous, active-low reset.
REQ-004 clr  input  1  Synchronous clear; highest priority among synchronous controls.
REQ-005 en  input  1  Advance permission; 0 = stall (all state held).
REQ-006 is_c  input  1  Current instruction is a C-instruction; jumps are evaluated only when 1.
REQ-007 jbits  input  3  Hack jump field {j1,j2,j3}.
REQ-008 zr  input  1  ALU output equals zero.
REQ-009 ng  input  1  ALU output is negative.
REQ-010 target  input  WORD_W  Jump destination (A register value).
REQ-011 pc  output  WORD_W  Registered program counter (address of the next fetch).
REQ-012 jumped  output  1  Registered; 1 when the last pc update was a taken jump.
REQ-013 flush  output  1  Moore output; 1 while in state FLUSH (the fetched instruction is discarded).
REQ-014 wrapped  output  1  Sticky; 1 once pc has incremented from all-ones to zero.

Function
REQ-015 take SHALL equal is_c & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr)); no other jump logic.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, FLUSH.
REQ-017 IDLE: pc held at 0; en=1 -> RUN with pc unchanged, so the first fetch is address 0.
REQ-018 RUN, en=0: pc, jumped and state are held.
REQ-019 RUN, en=1, take=1: pc <= target; jumped <= 1; state -> FLUSH.
REQ-020 RUN, en=1, take=0: pc <= pc + 1, modulo 2^WORD_W; jumped <= 0.
REQ-021 FLUSH: pc is held and take is ignored; en=1 -> RUN with jumped <= 0; en=0 -> remain in FLUSH.
REQ-022 flush SHALL be 1 exactly for the cycles spent in FLUSH, and 0 in IDLE and RUN.
REQ-023 Increment from all-ones to 0 SHALL set wrapped <= 1 the same edge; a jump to target 0 SHALL NOT set it.
REQ-024 wrapped SHALL hold at 1 until clr or reset.
REQ-025 clr=1 at an edge SHALL force pc=0, jumped=0, wrapped=0, state IDLE, regardless of en, take or current state.
REQ-026 Latency: a jump is visible on pc one clock after the qualifying edge inputs.
REQ-027 zr=1 & ng=1 (illegal ALU flags) SHALL be evaluated by REQ-015 unchanged, with no special case.

Reset
REQ-028 rst_n=0 SHALL immediately force pc=0, jumped=0, wrapped=0, state IDLE (so flush=0), independent of clk.
REQ-029 Deassertion of rst_n mid-operation SHALL resume from IDLE on the next qualifying edge; no pre-reset state is retained.

Structure
REQ-030 A shared package hack_pkg SHALL hold the WORD_W default (16), the FSM state enum, and named jbits constants JNULL=000 through JMP=111.
REQ-031 Jump-condition evaluation SHALL be a combinational sub-module hack_jump_cond (jbits, zr, ng, is_c -> take); all registers SHALL stay in hack_pc_ctrl.

Verification
REQ-032 Reset and start: rst_n low -> pc=0, flags 0; release, en=1 for 4 edges, no jumps -> pc sequence 0,0,1,2,3.
REQ-033 All 8 jbits values x {ng=1; zr=1; both 0} in RUN with target=0x1234 and is_c=1 -> pc=0x1234 exactly when REQ-015 holds, else pc+1. Repeating with is_c=0 -> never jumps.
REQ-034 Taken jump then en=0 for 2 cycles -> flush=1 for 3 cycles, pc stays 0x1234. Then en=1 -> flush=0, pc=0x1235 on the following edge.
REQ-035 Wrap: drive pc to 0xFFFF via jump, then increment -> pc=0x0000 and wrapped=1. jbits=111 with target=0 -> wrapped stays unchanged; clr -> wrapped=0.
REQ-036 Simultaneous events: clr=1 with take=1 and en=1 -> pc=0, state IDLE. rst_n pulsed low between edges in FLUSH -> outputs cleared immediately, not at the edge.
